// File: rtl/dmac_ahb_slave_nch_pkg.sv
//------------------------------------------------------------------------------
// Module   : dmac_pkg
// Purpose  : Shared constants for the DMAC AHB slave front-end.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package dmac_pkg;

  localparam logic [1:0] c_HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] c_HTRANS_SEQ    = 2'b11;
  localparam logic [1:0] c_HRESP_OKAY    = 2'b00;
  localparam logic [1:0] c_HRESP_ERROR   = 2'b01;
  localparam logic [2:0] c_HSIZE_WORD    = 3'b010;

  // Global offsets are absolute; channel offsets are relative to the channel block
  localparam int unsigned c_OFF_INTSTAT = 'h000;
  localparam int unsigned c_OFF_GCFG    = 'h030;
  localparam int unsigned c_OFF_SRC     = 'h00;
  localparam int unsigned c_OFF_DST     = 'h04;
  localparam int unsigned c_OFF_CTRL    = 'h0C;
  localparam int unsigned c_OFF_CCFG    = 'h10;

  typedef enum logic [2:0] {
    c_SEL_GCFG    = 3'd0,
    c_SEL_INTSTAT = 3'd1,
    c_SEL_SRC     = 3'd2,
    c_SEL_DST     = 3'd3,
    c_SEL_CTRL    = 3'd4,
    c_SEL_CCFG    = 3'd5
  } reg_sel_e;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmac_ahb_slave_nch_if.sv
//------------------------------------------------------------------------------
// Module   : dmac_ahb_slave_nch_if
// Purpose  : AHB-Lite slave-side bus bundle for the DMAC register front-end.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface dmac_ahb_slave_nch_if #(
  parameter int ADDR_W = 12
);
  logic              s_HSEL;
  logic [ADDR_W-1:0] s_HADDR;
  logic [1:0]        s_HTRANS;
  logic              s_HWRITE;
  logic [2:0]        s_HSIZE;
  logic              s_HREADY;
  logic [31:0]       s_HWDATA;
  logic [31:0]       s_out_HRDATA;
  logic              s_out_HREADY;
  logic [1:0]        s_out_HRESP;

  modport master (
    output s_HSEL, s_HADDR, s_HTRANS, s_HWRITE, s_HSIZE, s_HREADY, s_HWDATA,
    input  s_out_HRDATA, s_out_HREADY, s_out_HRESP
  );

  modport slave (
    input  s_HSEL, s_HADDR, s_HTRANS, s_HWRITE, s_HSIZE, s_HREADY, s_HWDATA,
    output s_out_HRDATA, s_out_HREADY, s_out_HRESP
  );
endinterface

`default_nettype wire

// File: rtl/dmac_ahb_slave_nch_decode.sv
//------------------------------------------------------------------------------
// Module   : dmac_addr_decode
// Purpose  : Combinational address/size/direction decode into register select.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dmac_addr_decode
  import dmac_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int ADDR_W    = 12,
  parameter int CH_BASE   = 'h100,
  parameter int CH_STRIDE = 'h020,
  parameter int CH_W      = 2
) (
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_write,
  input  logic [2:0]        i_size,
  output logic              o_valid,
  output logic [2:0]        o_sel,
  output logic [CH_W-1:0]   o_ch
);

  localparam int SH = $clog2(CH_STRIDE);

  logic [ADDR_W-1:0] w_rel;
  logic [ADDR_W-1:0] w_idx;
  logic [ADDR_W-1:0] w_off;
  logic              w_in_ch;

  always_comb begin
    w_rel   = i_addr - ADDR_W'(CH_BASE);
    w_idx   = w_rel >> SH;
    w_off   = w_rel & ADDR_W'(CH_STRIDE - 1);
    w_in_ch = (i_addr >= ADDR_W'(CH_BASE)) && (w_idx < ADDR_W'(NUM_CH));

    o_valid = 1'b0;
    o_sel   = c_SEL_GCFG;
    o_ch    = '0;

    if (i_addr == ADDR_W'(c_OFF_INTSTAT)) begin
      o_sel   = c_SEL_INTSTAT;
      o_valid = !i_write;  // status is read-only
    end else if (i_addr == ADDR_W'(c_OFF_GCFG)) begin
      o_valid = 1'b1;
    end else if (w_in_ch) begin
      o_ch    = w_idx[CH_W-1:0];
      o_valid = 1'b1;
      case (w_off)
        ADDR_W'(c_OFF_SRC):  o_sel = c_SEL_SRC;
        ADDR_W'(c_OFF_DST):  o_sel = c_SEL_DST;
        ADDR_W'(c_OFF_CTRL): o_sel = c_SEL_CTRL;
        ADDR_W'(c_OFF_CCFG): o_sel = c_SEL_CCFG;
        default:             o_valid = 1'b0;
      endcase
    end

    if ((i_size != c_HSIZE_WORD) || (i_addr[1:0] != 2'b00)) begin
      o_valid = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dmac_ahb_slave_nch.sv
//------------------------------------------------------------------------------
// Module   : dmac_ahb_slave_nch
// Purpose  : AHB-Lite slave front-end for the N-channel DMAC register bank.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dmac_ahb_slave_nch
  import dmac_pkg::*;
#(
  parameter  int NUM_CH      = 4,
  parameter  int ADDR_W      = 12,
  parameter  int CH_BASE     = 'h100,
  parameter  int CH_STRIDE   = 'h020,
  parameter  int WAIT_STATES = 0,
  localparam int CH_W        = ch_width(NUM_CH)
) (
  input  logic                  s_HCLK,
  input  logic                  s_HRESETn,
  dmac_ahb_slave_nch_if.slave   bus,
  output logic                  reg_wr_en,
  output logic [31:0]           reg_wdata,
  output logic [2:0]            reg_sel,
  output logic [CH_W-1:0]       reg_ch,
  input  logic [31:0]           reg_rdata
);

  localparam logic [2:0] c_ST_IDLE = 3'd0;
  localparam logic [2:0] c_ST_WAIT = 3'd1;
  localparam logic [2:0] c_ST_DATA = 3'd2;
  localparam logic [2:0] c_ST_ERR1 = 3'd3;
  localparam logic [2:0] c_ST_ERR2 = 3'd4;

  logic [2:0]      r_state;
  logic [2:0]      r_wait_cnt;
  logic            r_write;
  logic            w_accept;
  logic            w_valid;
  logic [2:0]      w_sel;
  logic [CH_W-1:0] w_ch;

  dmac_addr_decode #(
    .NUM_CH    (NUM_CH),
    .ADDR_W    (ADDR_W),
    .CH_BASE   (CH_BASE),
    .CH_STRIDE (CH_STRIDE),
    .CH_W      (CH_W)
  ) u_decode (
    .i_addr  (bus.s_HADDR),
    .i_write (bus.s_HWRITE),
    .i_size  (bus.s_HSIZE),
    .o_valid (w_valid),
    .o_sel   (w_sel),
    .o_ch    (w_ch)
  );

  assign w_accept = bus.s_out_HREADY && bus.s_HSEL && bus.s_HREADY &&
                    ((bus.s_HTRANS == c_HTRANS_NONSEQ) || (bus.s_HTRANS == c_HTRANS_SEQ));

  always_ff @(posedge s_HCLK or negedge s_HRESETn) begin
    if (!s_HRESETn) begin
      r_state    <= c_ST_IDLE;
      r_wait_cnt <= 3'd0;
      r_write    <= 1'b0;
      reg_sel    <= 3'd0;
      reg_ch     <= '0;
    end else begin
      case (r_state)
        c_ST_WAIT: begin
          if (r_wait_cnt == 3'd1) begin
            r_state <= c_ST_DATA;
          end
          r_wait_cnt <= r_wait_cnt - 3'd1;
        end
        c_ST_ERR1: r_state <= c_ST_ERR2;
        default: begin
          // IDLE, DATA and ERR2 drive HREADY high, so a new address phase may land here
          if (w_accept) begin
            if (!w_valid) begin
              r_state <= c_ST_ERR1;
            end else begin
              r_write <= bus.s_HWRITE;
              reg_sel <= w_sel;
              reg_ch  <= w_ch;
              if (WAIT_STATES > 0) begin
                r_state    <= c_ST_WAIT;
                r_wait_cnt <= 3'(WAIT_STATES);
              end else begin
                r_state <= c_ST_DATA;
              end
            end
          end else begin
            r_state <= c_ST_IDLE;
          end
        end
      endcase
    end
  end

  always_comb begin
    bus.s_out_HREADY = !((r_state == c_ST_WAIT) || (r_state == c_ST_ERR1));
    bus.s_out_HRESP  = ((r_state == c_ST_ERR1) || (r_state == c_ST_ERR2)) ? c_HRESP_ERROR
                                                                           : c_HRESP_OKAY;
    reg_wr_en        = (r_state == c_ST_DATA) && r_write;
    bus.s_out_HRDATA = ((r_state == c_ST_DATA) && !r_write) ? reg_rdata : 32'h0;
  end

  assign reg_wdata = bus.s_HWDATA;

endmodule

`default_nettype wire

// File: tb/tb_dmac_ahb_slave_nch.sv
//------------------------------------------------------------------------------
// Module   : tb_dmac_ahb_slave_nch
// Purpose  : Self-checking bench; zero-wait and two-wait instances share one bank.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_dmac_ahb_slave_nch;

  localparam logic [31:0] INTSTAT_V = 32'hA5A5_0F0F;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dsel = 1'b0;
  logic        hsel = 1'b0;
  logic [11:0] haddr = '0;
  logic [1:0]  htrans = 2'b00;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = 3'b010;
  logic [31:0] hwdata = '0;

  int checks = 0;
  int failures = 0;
  bit pre = 1'b0;
  logic [31:0] mem [int];
  logic [31:0] bank [8][4];

  dmac_ahb_slave_nch_if #(.ADDR_W(12)) if0 ();
  dmac_ahb_slave_nch_if #(.ADDR_W(12)) if1 ();

  logic        wr0, wr1;
  logic [31:0] wd0, wd1, rd0, rd1;
  logic [2:0]  sel0, sel1;
  logic [1:0]  ch0, ch1;

  assign if0.s_HSEL   = hsel && !dsel;
  assign if1.s_HSEL   = hsel && dsel;
  assign if0.s_HADDR  = haddr;   assign if1.s_HADDR  = haddr;
  assign if0.s_HTRANS = htrans;  assign if1.s_HTRANS = htrans;
  assign if0.s_HWRITE = hwrite;  assign if1.s_HWRITE = hwrite;
  assign if0.s_HSIZE  = hsize;   assign if1.s_HSIZE  = hsize;
  assign if0.s_HWDATA = hwdata;  assign if1.s_HWDATA = hwdata;
  assign if0.s_HREADY = if0.s_out_HREADY;
  assign if1.s_HREADY = if1.s_out_HREADY;
  assign rd0 = bank[sel0][ch0];
  assign rd1 = bank[sel1][ch1];

  dmac_ahb_slave_nch #(.WAIT_STATES(0)) u_dut0 (
    .s_HCLK(clk), .s_HRESETn(rst_n), .bus(if0),
    .reg_wr_en(wr0), .reg_wdata(wd0), .reg_sel(sel0), .reg_ch(ch0), .reg_rdata(rd0));

  dmac_ahb_slave_nch #(.WAIT_STATES(2)) u_dut1 (
    .s_HCLK(clk), .s_HRESETn(rst_n), .bus(if1),
    .reg_wr_en(wr1), .reg_wdata(wd1), .reg_sel(sel1), .reg_ch(ch1), .reg_rdata(rd1));

  wire        obs_hready = dsel ? if1.s_out_HREADY : if0.s_out_HREADY;
  wire [1:0]  obs_resp   = dsel ? if1.s_out_HRESP  : if0.s_out_HRESP;
  wire [31:0] obs_rdata  = dsel ? if1.s_out_HRDATA : if0.s_out_HRDATA;
  wire        obs_wr     = dsel ? wr1 : wr0;
  wire [31:0] obs_wdata  = dsel ? wd1 : wd0;
  wire [2:0]  obs_sel    = dsel ? sel1 : sel0;
  wire [1:0]  obs_ch     = dsel ? ch1 : ch0;

  always #5 clk = ~clk;

  // Register bank behind both slaves
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < 8; s++)
        for (int c = 0; c < 4; c++)
          bank[s][c] <= (s == 1) ? INTSTAT_V : 32'h0;
      bank[4][2] <= 32'h1234;
    end else begin
      if (wr0) bank[sel0][ch0] <= wd0;
      if (wr1) bank[sel1][ch1] <= wd1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Register map rules expressed as address arithmetic
  function automatic void model(input logic [11:0] a, input bit w, input logic [2:0] s,
                                output bit ok, output logic [2:0] sel, output logic [1:0] ch);
    int r, n, o;
    ok = 1'b0; sel = 3'd0; ch = 2'd0;
    if (a == 12'h000) begin
      sel = 3'd1; ok = !w;
    end else if (a == 12'h030) begin
      ok = 1'b1;
    end else if (a >= 12'h100) begin
      r = int'(a) - 'h100; n = r / 'h20; o = r % 'h20;
      if (n < 4) begin
        ch = 2'(n); ok = 1'b1;
        case (o)
          0:  sel = 3'd2;
          4:  sel = 3'd3;
          12: sel = 3'd4;
          16: sel = 3'd5;
          default: ok = 1'b0;
        endcase
      end
    end
    if (s != 3'b010 || a[1:0] != 2'b00) ok = 1'b0;
  endfunction

  task automatic drive(input logic [11:0] a, input bit w, input logic [2:0] s);
    hsel = 1'b1; haddr = a; hwrite = w; hsize = s;
    htrans = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b11;
  endtask

  task automatic xfer(input logic [11:0] a, input bit w, input logic [2:0] s, input logic [31:0] wd,
                      input bit chain, input logic [11:0] na, input bit nw, input logic [2:0] ns);
    bit ok; logic [2:0] es; logic [1:0] ec; int ws;
    ws = dsel ? 2 : 0;
    model(a, w, s, ok, es, ec);
    if (!pre) begin
      chk("addr_hready", 32'(obs_hready), 32'd1);
      drive(a, w, s);
    end
    @(posedge clk);
    @(negedge clk);
    hsel = 1'b0; htrans = 2'b00; hwdata = wd;
    #1;
    if (ok) begin
      for (int i = 0; i < ws; i++) begin
        chk("wait_hready", 32'(obs_hready), 32'd0);
        chk("wait_resp", 32'(obs_resp), 32'd0);
        chk("wait_wr_en", 32'(obs_wr), 32'd0);
        @(negedge clk); #1;
      end
      chk("data_hready", 32'(obs_hready), 32'd1);
      chk("data_resp", 32'(obs_resp), 32'd0);
      chk("data_wr_en", 32'(obs_wr), 32'(w));
      chk("data_sel", 32'(obs_sel), 32'(es));
      chk("data_ch", 32'(obs_ch), 32'(ec));
      if (w) begin
        chk("data_wdata", obs_wdata, wd);
        mem[int'(a)] = wd;
      end else begin
        chk("data_rdata", obs_rdata, mem.exists(int'(a)) ? mem[int'(a)] : 32'h0);
      end
    end else begin
      chk("err1_hready", 32'(obs_hready), 32'd0);
      chk("err1_resp", 32'(obs_resp), 32'd1);
      chk("err1_wr_en", 32'(obs_wr), 32'd0);
      @(negedge clk); #1;
      chk("err2_hready", 32'(obs_hready), 32'd1);
      chk("err2_resp", 32'(obs_resp), 32'd1);
      chk("err2_wr_en", 32'(obs_wr), 32'd0);
      chk("err2_rdata", obs_rdata, 32'h0);
    end
    pre = chain;
    if (chain) drive(na, nw, ns);
  endtask

  function automatic logic [11:0] rand_addr();
    int offs [6];
    int k;
    offs = '{0, 4, 8, 12, 16, 20};
    k = $urandom_range(0, 9);
    case (k)
      0: return 12'h000;
      1: return 12'h030;
      8: return 12'($urandom) & 12'hFFC;
      9: return 12'($urandom);
      default: return 12'('h100 + $urandom_range(0, 5) * 'h20 + offs[$urandom_range(0, 5)]);
    endcase
  endfunction

  initial begin
    logic [11:0] ta [30];
    bit          tw [30];
    logic [2:0]  ts [30];
    logic [31:0] td [30];
    bit          tc [30];

    mem[0] = INTSTAT_V;
    mem['h14C] = 32'h1234;

    #1;
    dsel = 1'b0; #1;
    chk("rst0_hready", 32'(obs_hready), 32'd1);
    chk("rst0_resp", 32'(obs_resp), 32'd0);
    chk("rst0_rdata", obs_rdata, 32'h0);
    chk("rst0_wr_en", 32'(obs_wr), 32'd0);
    dsel = 1'b1; #1;
    chk("rst1_sel", 32'(obs_sel), 32'd0);
    chk("rst1_ch", 32'(obs_ch), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    dsel = 1'b0;
    xfer(12'h100, 1, 3'b010, 32'hDEAD_BEEF, 0, '0, 0, '0);
    dsel = 1'b1;
    xfer(12'h14C, 0, 3'b010, 32'h0, 0, '0, 0, '0);
    xfer(12'h108, 1, 3'b010, 32'h1111_2222, 0, '0, 0, '0);
    xfer(12'h000, 1, 3'b010, 32'h3333_4444, 0, '0, 0, '0);
    xfer(12'h000, 0, 3'b010, 32'h0, 0, '0, 0, '0);
    xfer(12'h030, 0, 3'b000, 32'h0, 0, '0, 0, '0);
    dsel = 1'b0;
    xfer(12'h124, 1, 3'b010, 32'h55AA_1357, 0, '0, 0, '0);
    xfer(12'h104, 1, 3'b010, 32'hCAFE_0104, 1, 12'h124, 0, 3'b010);
    xfer(12'h124, 0, 3'b010, 32'h0, 0, '0, 0, '0);
    dsel = 1'b1;
    xfer(12'h170, 1, 3'b010, 32'h0BAD_F00D, 1, 12'h170, 0, 3'b010);
    xfer(12'h170, 0, 3'b010, 32'h0, 0, '0, 0, '0);

    // BUSY transfer: no action, zero-wait OKAY
    hsel = 1'b1; haddr = 12'h100; hwrite = 1'b1; hsize = 3'b010; htrans = 2'b01;
    @(posedge clk); @(negedge clk); #1;
    chk("busy_hready", 32'(obs_hready), 32'd1);
    chk("busy_resp", 32'(obs_resp), 32'd0);
    chk("busy_wr_en", 32'(obs_wr), 32'd0);
    hsel = 1'b0; htrans = 2'b00;

    // Randomized pipelined traffic on each instance
    for (int d = 0; d < 2; d++) begin
      dsel = d[0];
      for (int i = 0; i < 30; i++) begin
        ta[i] = rand_addr();
        tw[i] = $urandom_range(0, 1) == 1;
        ts[i] = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 3)) : 3'b010;
        td[i] = $urandom;
        tc[i] = (i < 29) && ($urandom_range(0, 1) == 1);
      end
      for (int i = 0; i < 30; i++)
        xfer(ta[i], tw[i], ts[i], td[i], tc[i],
             ta[(i + 1) % 30], tw[(i + 1) % 30], ts[(i + 1) % 30]);
      @(negedge clk);
    end

    // Reset during the wait phase of a write
    dsel = 1'b1;
    drive(12'h10C, 1, 3'b010);
    @(posedge clk); @(negedge clk);
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'hFEED_FACE; #1;
    chk("pre_rst_hready", 32'(obs_hready), 32'd0);
    rst_n = 1'b0; #1;
    chk("mid_rst_hready", 32'(obs_hready), 32'd1);
    chk("mid_rst_resp", 32'(obs_resp), 32'd0);
    chk("mid_rst_rdata", obs_rdata, 32'h0);
    chk("mid_rst_sel", 32'(obs_sel), 32'd0);
    chk("mid_rst_ch", 32'(obs_ch), 32'd0);
    for (int i = 0; i < 6; i++) begin
      chk("rst_no_wr_en", 32'(obs_wr), 32'd0);
      @(negedge clk); #1;
      if (i == 2) rst_n = 1'b1;
    end
    chk("post_rst_hready", 32'(obs_hready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
